// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: NUM_RW byte-strobed RW registers, NUM_RO status inputs,
// per-register write-commit pulses and SLVERR on read-only or unmapped accesses.
module axil_reg_bank #(
  parameter int unsigned              DATA_WIDTH = 32,
  parameter int unsigned              ADDR_WIDTH = 8,
  parameter int unsigned              NUM_RW     = 4,
  parameter int unsigned              NUM_RO     = 2,
  parameter logic [DATA_WIDTH-1:0]    RST_VAL    = '0
) (
  input  logic                                        S_AXI_ACLK,
  input  logic                                        S_AXI_ARESET,
  input  logic [ADDR_WIDTH-1:0]                       S_AXI_AWADDR,
  input  logic [2:0]                                  S_AXI_AWPROT,
  input  logic                                        S_AXI_AWVALID,
  output logic                                        S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]                       S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]                     S_AXI_WSTRB,
  input  logic                                        S_AXI_WVALID,
  output logic                                        S_AXI_WREADY,
  output logic [1:0]                                  S_AXI_BRESP,
  output logic                                        S_AXI_BVALID,
  input  logic                                        S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]                       S_AXI_ARADDR,
  input  logic [2:0]                                  S_AXI_ARPROT,
  input  logic                                        S_AXI_ARVALID,
  output logic                                        S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]                       S_AXI_RDATA,
  output logic [1:0]                                  S_AXI_RRESP,
  output logic                                        S_AXI_RVALID,
  input  logic                                        S_AXI_RREADY,
  output logic [NUM_RW*DATA_WIDTH-1:0]                reg_out,
  output logic [NUM_RW-1:0]                           wr_pulse,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] ro_in
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_WIDTH - LSB;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] r_regs [NUM_RW];
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [IDX_W-1:0]      r_aw_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [NUM_RW-1:0]     r_wr_pulse;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic                  w_aw_held_nx;
  logic                  w_w_held_nx;
  logic                  w_bvalid_nx;
  logic                  w_rvalid_nx;
  logic [NUM_RW-1:0]     w_wr_sel;
  logic                  w_wr_hit;
  logic [IDX_W-1:0]      w_ar_idx;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_rd_err;
  logic                  w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

  assign w_aw_hs  = S_AXI_AWVALID && r_awready;
  assign w_w_hs   = S_AXI_WVALID  && r_wready;
  assign w_ar_hs  = S_AXI_ARVALID && r_arready;
  assign w_commit = r_aw_held && r_w_held;
  assign w_ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:LSB];

  // Next-state of the write/read handshake flags; the READY registers track these
  always_comb begin
    w_aw_held_nx = r_aw_held || w_aw_hs;
    w_w_held_nx  = r_w_held  || w_w_hs;
    w_bvalid_nx  = r_bvalid && !S_AXI_BREADY;
    w_rvalid_nx  = w_ar_hs || (r_rvalid && !S_AXI_RREADY);
    if (w_commit) begin
      w_aw_held_nx = 1'b0;
      w_w_held_nx  = 1'b0;
      w_bvalid_nx  = 1'b1;
    end
  end

  // Write target decode from the held address
  always_comb begin
    w_wr_sel = '0;
    w_wr_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (r_aw_idx == IDX_W'(i)) begin
        w_wr_sel[i] = 1'b1;
        w_wr_hit    = 1'b1;
      end
    end
  end

  // Read mux over RW registers then status slots; anything else decodes as an error
  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b1;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (w_ar_idx == IDX_W'(i)) begin
        w_rd_data = r_regs[i];
        w_rd_err  = 1'b0;
      end
    end
    for (int unsigned j = 0; j < NUM_RO; j++) begin
      if (w_ar_idx == IDX_W'(NUM_RW + j)) begin
        w_rd_data = ro_in[j*DATA_WIDTH +: DATA_WIDTH];
        w_rd_err  = 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_awready  <= 1'b1;
      r_wready   <= 1'b1;
      r_bvalid   <= 1'b0;
      r_bresp    <= OKAY;
      r_wr_pulse <= '0;
      for (int unsigned i = 0; i < NUM_RW; i++) r_regs[i] <= RST_VAL;
    end else begin
      r_aw_held  <= w_aw_held_nx;
      r_w_held   <= w_w_held_nx;
      r_awready  <= !w_aw_held_nx && !w_bvalid_nx;
      r_wready   <= !w_w_held_nx  && !w_bvalid_nx;
      r_bvalid   <= w_bvalid_nx;
      r_wr_pulse <= w_commit ? w_wr_sel : '0;
      if (w_aw_hs) r_aw_idx <= S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) r_bresp <= w_wr_hit ? OKAY : SLVERR;
      // Byte-lane merge into the selected register
      for (int unsigned i = 0; i < NUM_RW; i++) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (w_commit && w_wr_sel[i] && r_wstrb[b]) r_regs[i][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
    end else begin
      r_rvalid  <= w_rvalid_nx;
      r_arready <= !w_rvalid_nx;
      if (w_ar_hs) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_err ? SLVERR : OKAY;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_reg_out
    assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign wr_pulse      = r_wr_pulse;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed self-checking bench for axil_reg_bank at default parameters (32-bit, 4 RW, 2 RO).
module tb_axil_reg_bank;

  logic         clk = 1'b0;
  logic         arst;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         arvalid, arready, rvalid, rready;
  logic [127:0] reg_out;
  logic [3:0]   wr_pulse;
  logic [63:0]  ro_in;

  int total = 0;
  int bad   = 0;
  int pulse_cnt [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  axil_reg_bank dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(arst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse), .ro_in(ro_in)
  );

  // Counts wr_pulse cycles per register
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (!arst && wr_pulse[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    int  n;
    bit  aw_go, w_go;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid  = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("wr_handshake", {awvalid, wvalid}, 2'b00);
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bvalid_wait", bvalid, 1'b1);
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    bit go;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      go = arready;
      @(posedge clk); #1;
      if (go) arvalid = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("ar_handshake", arvalid, 1'b0);
    arvalid = 1'b0;
    chk("rvalid_after_ar", rvalid, 1'b1);
    d = rdata;
    resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  logic [31:0]  t1_data [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
  logic [31:0]  rd;
  logic [1:0]   rsp;
  logic [127:0] exp_regs;
  int           base2;

  initial begin
    arst = 1'b1; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    ro_in = {32'h13572468, 32'hCAFEF00D};
    repeat (3) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;

    // Reset state
    chk("rst_ready", {awready, wready, arready}, 3'b111);
    chk("rst_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_resp", {bresp, rresp}, 4'b0000);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_pulse", wr_pulse, 4'h0);
    chk("rst_regs", reg_out, 128'h0);

    // 1: full-word writes with readback
    for (int i = 0; i < 4; i++) begin
      do_write(8'(i * 4), t1_data[i], 4'hF, rsp);
      chk("t1_bresp", rsp, 2'b00);
      do_read(8'(i * 4), rd, rsp);
      chk("t1_rdata", rd, t1_data[i]);
      chk("t1_rresp", rsp, 2'b00);
    end
    for (int i = 0; i < 4; i++) chk("t1_pulse_cnt", pulse_cnt[i], 1);

    // 2: partial strobes, lanes 0 and 2
    do_write(8'h00, 32'hDEAD0011, 4'hF, rsp);
    do_write(8'h00, 32'h12345678, 4'b0101, rsp);
    chk("t2_bresp", rsp, 2'b00);
    do_read(8'h00, rd, rsp);
    chk("t2_rdata", rd, 32'hDE340078);
    chk("t2_reg_out", reg_out[31:0], 32'hDE340078);

    // 3: W leads AW by two cycles, then BREADY stalled
    base2 = pulse_cnt[2];
    @(negedge clk);
    wdata = 32'h0F0F0F0F; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1; wvalid = 1'b0;
    @(negedge clk);
    chk("t3_wready_held", wready, 1'b0);
    chk("t3_awready_idle", awready, 1'b1);
    @(negedge clk);
    chk("t3_no_commit_b", bvalid, 1'b0);
    chk("t3_no_commit_reg", reg_out[95:64], 32'hDEAD0011);
    awaddr = 8'h08; awvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0;
    @(negedge clk);
    chk("t3_b_not_yet", bvalid, 1'b0);
    @(negedge clk);
    chk("t3_bvalid", bvalid, 1'b1);
    chk("t3_reg2", reg_out[95:64], 32'h0F0F0F0F);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_stall_b", {bvalid, bresp}, 3'b100);
      chk("t3_stall_ready", {awready, wready}, 2'b00);
    end
    bready = 1'b1;
    @(posedge clk); #1; bready = 1'b0;
    @(negedge clk);
    chk("t3_b_clear", bvalid, 1'b0);
    chk("t3_ready_back", {awready, wready}, 2'b11);
    chk("t3_pulse", pulse_cnt[2] - base2, 1);

    // 4: status read, read-only write, out-of-range read
    exp_regs = {32'hBEEF0011, 32'h0F0F0F0F, 32'hABCD0001, 32'hDE340078};
    do_read(8'h10, rd, rsp);
    chk("t4_ro_rdata", rd, 32'hCAFEF00D);
    chk("t4_ro_rresp", rsp, 2'b00);
    do_read(8'h17, rd, rsp);
    chk("t4_ro1_rdata", rd, 32'h13572468);
    do_write(8'h10, 32'hFFFFFFFF, 4'hF, rsp);
    chk("t4_ro_bresp", rsp, 2'b10);
    chk("t4_regs_kept", reg_out, exp_regs);
    chk("t4_no_pulse", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], 7);
    do_read(8'h40, rd, rsp);
    chk("t4_oor_rdata", rd, 32'h0);
    chk("t4_oor_rresp", rsp, 2'b10);

    // 5: read of reg1 on the commit edge sees the old value
    @(negedge clk);
    awaddr = 8'h04; wdata = 32'h55AA33CC; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    araddr = 8'h04; arvalid = 1'b1;
    @(posedge clk); #1; arvalid = 1'b0;
    @(negedge clk);
    chk("t5_both_valid", {bvalid, rvalid}, 2'b11);
    chk("t5_old_value", rdata, 32'hABCD0001);
    rready = 1'b1; bready = 1'b1;
    @(posedge clk); #1; rready = 1'b0; bready = 1'b0;
    do_read(8'h04, rd, rsp);
    chk("t5_new_value", rd, 32'h55AA33CC);

    // 6: reset with a pending write response and read
    @(negedge clk);
    awaddr = 8'h0C; wdata = 32'h11112222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h00; arvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_pending", {bvalid, rvalid}, 2'b11);
    arst = 1'b1;
    @(posedge clk); #1; arst = 1'b0;
    @(negedge clk);
    chk("t6_valids", {bvalid, rvalid}, 2'b00);
    chk("t6_readies", {awready, wready, arready}, 3'b111);
    chk("t6_regs", reg_out, 128'h0);
    chk("t6_rdata", rdata, 32'h0);
    @(negedge clk);
    chk("t6_no_resp", {bvalid, rvalid, wr_pulse}, 6'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
